seq_accum: RTL and testbench
============================

Name: seq_accum

Overview:
- Parametrised successor to the fixed 8-bit sum block. Accumulates a run-time count of unsigned samples delivered over a valid/ready handshake.
- Selectable wrap or saturate arithmetic, sticky overflow flag, one-cycle done pulse.
- Sits between a sample source (ADC/FIFO) and a consumer reading a held result.
- Replaces the free-running, unhandshaked 8-bit version.

Parameters:
- DATA_W, 8, sample width in bits.
- SUM_W, 16, accumulator/result width in bits; must be >= DATA_W.
- CNT_W, 8, width of sample-count request n_i; maximum run length is 2^CNT_W-1.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  request a run; sampled only in IDLE.
- n_i  in  CNT_W  number of samples for the run; latched on accepted start.
- sat_mode_i  in  1  0 = wrap modulo 2^SUM_W, 1 = saturate at 2^SUM_W-1; latched on accepted start.
- data_i  in  DATA_W  sample, zero-extended to SUM_W.
- data_valid_i  in  1  data_i is valid this cycle.
- data_ready_o  out  1  block accepts a sample this cycle.
- busy_o  out  1  high in ACCUM and DONE.
- done_o  out  1  one-cycle pulse when the result is final.
- sum_o  out  SUM_W  result of the last completed run; held until the next run completes.
- count_o  out  CNT_W  samples accepted so far in the current or last run.
- overflow_o  out  1  sticky for the run; set if any addition exceeded 2^SUM_W-1.

Behaviour:
- Reset (rst_i high at a clock edge, any state): state=IDLE; sum_o=0, count_o=0, overflow_o=0, done_o=0, data_ready_o=0, busy_o=0; internal accumulator cleared. Reset mid-run aborts the run with no done_o.
- States: IDLE, ACCUM, DONE (2-bit enum).
- IDLE:
  - data_ready_o=0.
  - start_i=1 at an edge: latch n_i and sat_mode_i; clear accumulator, count_o and overflow_o.
  - Go to ACCUM if n_i != 0, else go to DONE.
  - sum_o keeps its old value until DONE.
- ACCUM:
  - data_ready_o=1 (combinational from state).
  - A beat is accepted on an edge where data_valid_i=1 and data_ready_o=1.
  - On an accepted beat, count_o increments and the accumulator updates:
    - wrap mode: acc = (acc + data_i) mod 2^SUM_W; overflow_o set on carry-out.
    - saturate mode: on carry-out, acc = all-ones and overflow_o set.
  - Compute with a SUM_W+1-bit intermediate.
  - If the accepted beat makes count equal the latched n, go to DONE. Otherwise stay.
  - Cycles with data_valid_i=0 are stalls: no change.
  - start_i is ignored in ACCUM.
- DONE (exactly one cycle):
  - sum_o takes the accumulator value at entry to DONE and is visible in the DONE cycle.
  - done_o=1, data_ready_o=0, start_i ignored.
  - Next state is IDLE.
- Latency:
  - done_o is high in the cycle after the edge that accepted the last beat.
  - Minimum run (n=1, valid held high) from start edge to done_o: 2 edges.
  - n=0: done_o on the cycle after start, sum_o=0, overflow_o=0.
- count_o, overflow_o and sum_o are held in IDLE after a run until the next accepted start.
- Simultaneous rst_i and start_i: reset wins.

Decomposition:
- Package seq_accum_pkg holds:
  - the state typedef (IDLE=0, ACCUM=1, DONE=2);
  - the mode encoding constants MODE_WRAP=1'b0 and MODE_SAT=1'b1.
- One sub-module is natural: sat_adder (parameter SUM_W).
  - Inputs: a, b, sat.
  - Outputs: y, ovf.
  - Purely combinational; reused by future accumulate blocks.
- FSM, counter and registers stay in seq_accum.

Test Plan:
- DATA_W=8, SUM_W=16, wrap mode; start with n=4, data 10,20,30,40 with valid held high -> done_o one pulse 5 edges after start, sum_o=100, count_o=4, overflow_o=0.
- SUM_W=8, saturate mode, n=3, data 200,100,50 -> sum_o=255, overflow_o=1. Same run in wrap mode -> sum_o=94 (350 mod 256), overflow_o=1.
- n=0 -> done_o in the cycle after start, sum_o=0, count_o=0, data_ready_o never high.
- n=3 with data_valid_i toggled 1,0,0,1,0,1 on data 5,x,x,6,x,7 -> only 3 beats accepted, sum_o=18; start_i pulsed during ACCUM is ignored.
- Reset asserted after 2 of 4 beats -> all outputs 0 next cycle, no done_o. A fresh start with n=2, data 1,2 -> sum_o=3.
- Back-to-back runs: a second start one cycle after the done_o cycle (while in IDLE) -> sum_o of run 1 holds until run 2's DONE, overflow_o clears at the second start.

Source files
------------

// File: rtl/seq_accum_pkg.sv
// Shared types and constants for the handshaked sample accumulator.
package seq_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/seq_accum_sat.sv
// Combinational SUM_W-bit adder with carry-out flag and optional clamp to all-ones.
module sat_adder
  import seq_accum_pkg::*;
#(
  parameter int SUM_W = 16
) (
  input  logic [SUM_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  input  logic             sat,
  output logic [SUM_W-1:0] y,
  output logic             ovf
);

  logic [SUM_W:0] raw_s;

  // One extra bit catches the carry; saturate mode replaces a wrapped result with all-ones.
  always_comb begin
    raw_s = {1'b0, a} + {1'b0, b};
    ovf   = raw_s[SUM_W];
    if (raw_s[SUM_W] && (sat == MODE_SAT)) begin
      y = {SUM_W{1'b1}};
    end else begin
      y = raw_s[SUM_W-1:0];
    end
  end

endmodule

// File: rtl/seq_accum.sv
// Accumulates a requested number of unsigned samples over valid/ready and holds the result.
module seq_accum
  import seq_accum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_i,
  input  logic              sat_mode_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [SUM_W-1:0]  sum_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic               sat_q, sat_d;
  logic               ovf_q, ovf_d;

  logic               beat_s;
  logic               last_beat_s;
  logic [SUM_W-1:0]   data_ext_s;
  logic [SUM_W-1:0]   add_y_s;
  logic               add_ovf_s;

  assign data_ext_s  = SUM_W'(data_i);
  assign beat_s      = (state_q == ACCUM) && data_valid_i;
  assign last_beat_s = beat_s && ((cnt_q + CNT_ONE) == n_q);

  sat_adder #(
    .SUM_W (SUM_W)
  ) u_add (
    .a   (acc_q),
    .b   (data_ext_s),
    .sat (sat_q),
    .y   (add_y_s),
    .ovf (add_ovf_s)
  );

  // State register and datapath flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      sat_q   <= MODE_WRAP;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (n_i != '0) ? ACCUM : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (last_beat_s) begin
          state_d = DONE;
        end else begin
          state_d = ACCUM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: clear on accepted start, accumulate on accepted beats, publish on DONE entry.
  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    n_d   = n_q;
    sat_d = sat_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          n_d   = n_i;
          sat_d = sat_mode_i;
        end else begin
          acc_d = acc_q;
        end
      end
      ACCUM: begin
        if (beat_s) begin
          acc_d = add_y_s;
          cnt_d = cnt_q + CNT_ONE;
          ovf_d = ovf_q | add_ovf_s;
        end else begin
          acc_d = acc_q;
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
    if ((state_d == DONE) && (state_q != DONE)) begin
      sum_d = acc_d;
    end else begin
      sum_d = sum_q;
    end
  end

  // Outputs decoded from the state register and held flops.
  always_comb begin
    data_ready_o = (state_q == ACCUM);
    busy_o       = (state_q == ACCUM) || (state_q == DONE);
    done_o       = (state_q == DONE);
    sum_o        = sum_q;
    count_o      = cnt_q;
    overflow_o   = ovf_q;
  end

endmodule

// File: tb/tb_seq_accum.sv
// Directed scoreboard bench: a 16-bit and an 8-bit accumulator share one stimulus stream.
module tb_seq_accum;
  import seq_accum_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, start_i, sat_mode_i, data_valid_i;
  logic [7:0]  n_i, data_i;
  logic        rdy16, busy16, done16, ovf16;
  logic [15:0] sum16;
  logic [7:0]  cnt16;
  logic        rdy8, busy8, done8, ovf8;
  logic [7:0]  sum8, cnt8;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int sum16; bit ovf16; int sum8; bit ovf8; int cnt; int lat;
  } exp_t;
  exp_t sb_q[$];

  int pat_v[16];
  int pat_d[16];
  int pat_len;

  always #5 clk = ~clk;

  seq_accum #(.DATA_W(8), .SUM_W(16), .CNT_W(8)) u_dut16 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .n_i(n_i), .sat_mode_i(sat_mode_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(rdy16), .busy_o(busy16),
    .done_o(done16), .sum_o(sum16), .count_o(cnt16), .overflow_o(ovf16));

  seq_accum #(.DATA_W(8), .SUM_W(8), .CNT_W(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .n_i(n_i), .sat_mode_i(sat_mode_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(rdy8), .busy_o(busy8),
    .done_o(done8), .sum_o(sum8), .count_o(cnt8), .overflow_o(ovf8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_acc(input int w, input bit sat, input int n,
                                    output int s, output bit o, output int c);
    int mx;
    mx = (1 << w) - 1;
    s = 0; o = 1'b0; c = 0;
    for (int k = 0; k < pat_len; k++) begin
      if (pat_v[k] != 0 && c < n) begin
        s = s + pat_d[k];
        c++;
        if (s > mx) begin
          o = 1'b1;
          s = sat ? mx : s - (mx + 1);
        end
      end
    end
  endfunction

  task automatic start_run(input int n, input bit sat, input bit push);
    exp_t e;
    int   c8;
    int   c;
    model_acc(16, sat, n, e.sum16, e.ovf16, e.cnt);
    model_acc(8, sat, n, e.sum8, e.ovf8, c8);
    e.lat = 1;
    c = 0;
    for (int k = 0; k < pat_len; k++) begin
      if (pat_v[k] != 0 && c < n) begin
        c++;
        if (c == n) e.lat = k + 2;
      end
    end
    if (push) sb_q.push_back(e);
    n_i = 8'(n); sat_mode_i = sat; start_i = 1'b1;
    tick();
    start_i = 1'b0; n_i = 8'd0;
  endtask

  task automatic feed(input string tag, input int pulse_at);
    int   edges;
    bit   seen;
    exp_t e;
    edges = 1;
    seen  = done16;
    for (int k = 0; k < pat_len && !seen; k++) begin
      data_valid_i = (pat_v[k] != 0);
      data_i       = 8'(pat_d[k]);
      start_i      = (k == pulse_at);
      tick();
      edges++;
      if (done16) seen = 1'b1;
    end
    data_valid_i = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      edges++;
      if (done16) seen = 1'b1;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " latency"}, 32'(edges), 32'(e.lat));
      chk({tag, " done8"}, 32'(done8), 32'd1);
      chk({tag, " sum16"}, 32'(sum16), 32'(e.sum16));
      chk({tag, " ovf16"}, 32'(ovf16), 32'(e.ovf16));
      chk({tag, " sum8"}, 32'(sum8), 32'(e.sum8));
      chk({tag, " ovf8"}, 32'(ovf8), 32'(e.ovf8));
      chk({tag, " cnt16"}, 32'(cnt16), 32'(e.cnt));
      chk({tag, " cnt8"}, 32'(cnt8), 32'(e.cnt));
      chk({tag, " ready_in_done"}, 32'(rdy16), 32'd0);
      chk({tag, " busy_in_done"}, 32'(busy16), 32'd1);
    end
    tick();
    chk({tag, " done_one_cycle"}, 32'(done16), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy16), 32'd0);
  endtask

  task automatic set_pat(input int len, input int v[16], input int d[16]);
    pat_len = len;
    pat_v = v;
    pat_d = d;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; n_i = 8'd0; sat_mode_i = 1'b0;
    data_i = 8'd0; data_valid_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst sum16", 32'(sum16), 32'd0);
    chk("rst cnt16", 32'(cnt16), 32'd0);
    chk("rst ovf16", 32'(ovf16), 32'd0);
    chk("rst done16", 32'(done16), 32'd0);
    chk("rst rdy16", 32'(rdy16), 32'd0);
    chk("rst busy16", 32'(busy16), 32'd0);

    // n=4, wrap, valid held high
    set_pat(4, '{1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0}, '{10,20,30,40,0,0,0,0,0,0,0,0,0,0,0,0});
    start_run(4, MODE_WRAP, 1'b1);
    chk("A busy_after_start", 32'(busy16), 32'd1);
    chk("A ready_after_start", 32'(rdy16), 32'd1);
    feed("A", -1);

    // 200+100+50 saturating, then wrapping
    set_pat(3, '{1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0}, '{200,100,50,0,0,0,0,0,0,0,0,0,0,0,0,0});
    start_run(3, MODE_SAT, 1'b1);
    feed("B_sat", -1);
    start_run(3, MODE_WRAP, 1'b1);
    feed("C_wrap", -1);

    // n=0: straight to DONE, ready never raised
    set_pat(0, '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
    start_run(0, MODE_WRAP, 1'b1);
    chk("D ready_n0", 32'(rdy16), 32'd0);
    feed("D_n0", -1);
    chk("D ready_after", 32'(rdy16), 32'd0);

    // Stalls plus an ignored start pulse in ACCUM
    set_pat(6, '{1,0,0,1,0,1,0,0,0,0,0,0,0,0,0,0}, '{5,99,99,6,99,7,0,0,0,0,0,0,0,0,0,0});
    start_run(3, MODE_WRAP, 1'b1);
    feed("E_stall", 2);

    // Reset after two of four beats
    set_pat(4, '{1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0}, '{9,9,9,9,0,0,0,0,0,0,0,0,0,0,0,0});
    start_run(4, MODE_WRAP, 1'b0);
    data_valid_i = 1'b1; data_i = 8'd9;
    tick(); tick();
    chk("F cnt_mid", 32'(cnt16), 32'd2);
    rst_i = 1'b1; data_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    chk("F rst sum16", 32'(sum16), 32'd0);
    chk("F rst cnt16", 32'(cnt16), 32'd0);
    chk("F rst busy16", 32'(busy16), 32'd0);
    chk("F rst done16", 32'(done16), 32'd0);
    chk("F rst rdy16", 32'(rdy16), 32'd0);
    tick();
    chk("F no_done", 32'(done16), 32'd0);
    set_pat(2, '{1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, '{1,2,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
    start_run(2, MODE_WRAP, 1'b1);
    feed("F_fresh", -1);

    // Back-to-back: results of run 1 held until run 2 completes
    set_pat(2, '{1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, '{200,100,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
    start_run(2, MODE_WRAP, 1'b1);
    feed("G_run1", -1);
    chk("G hold sum8", 32'(sum8), 32'd44);
    chk("G hold ovf8", 32'(ovf8), 32'd1);
    chk("G hold sum16", 32'(sum16), 32'd300);
    chk("G hold cnt16", 32'(cnt16), 32'd2);
    set_pat(1, '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, '{7,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
    start_run(1, MODE_WRAP, 1'b1);
    chk("G ovf8_cleared", 32'(ovf8), 32'd0);
    chk("G sum8_still_held", 32'(sum8), 32'd44);
    chk("G cnt_cleared", 32'(cnt16), 32'd0);
    feed("G_run2", -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
